button_conditioner: RTL
=======================

Name: button_conditioner

Overview:
- Front-end input stage for the tic-tac-toe board controller.
- Takes the five raw, asynchronous push-button inputs (up, down, left, right, center) and produces clean outputs for the controller's press/release state machine:
  - synchronized, debounced level signals;
  - single-cycle press pulses;
  - an all-released flag.
- Sits between the board pins and the controller, in the same clk domain.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive clk cycles a synchronized input must hold a new value before the debounced level changes. Legal range is 2 or more.
- CNT_W, 20: debounce counter width. Must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock; all state on posedge clk.
- rst  input  1  asynchronous, active-high reset.
- btn_raw  input  5  raw buttons {center, down, up, left, right}, bit 0 = right; asynchronous and bouncing.
- btn_level  output  5  debounced levels, same bit order.
- btn_pulse  output  5  one-cycle press pulses, same bit order; at most one bit set per cycle.
- all_released  output  1  high when btn_level == 0.
- dropped  output  1  one-cycle flag: a simultaneous press was suppressed by priority.

Behaviour:
- Reset is asynchronous and active-high. While rst=1, every register clears:
  - synchronizer flops = 0, counters = 0, btn_level = 0, btn_pulse = 0, dropped = 0;
  - all_released = 1, since it is derived from btn_level.
- Release of reset takes effect on the next posedge, with no extra latency.
- Synchronizer:
  - Each btn_raw bit passes through a 2-flop chain. The second flop is s[i].
  - s[i] follows btn_raw[i] after 2 clk edges.
- Debounce, per bit, independent counter cnt[i]:
  - If s[i] == btn_level[i]: cnt[i] <= 0.
  - Else if cnt[i] == DEBOUNCE_CYCLES-1: btn_level[i] <= s[i] and cnt[i] <= 0.
  - Else: cnt[i] <= cnt[i]+1.
  - Any bounce back to the old value before the terminal count restarts the count from 0.
  - Latency: btn_raw stable from cycle 0 gives btn_level changing at edge 2+DEBOUNCE_CYCLES. Release uses the same rule and the same latency.
- Press detect:
  - rise[i] = the debounced level is about to go 0->1 at this edge.
- Pulse generation, registered:
  - On the edge where btn_level[i] rises, btn_pulse has exactly one bit set for exactly one cycle.
  - Falling edges produce no pulse.
- Priority when several rise[i] occur on the same edge:
  - Order is right > left > up > down > center, matching the controller's decode order.
  - Only the highest-priority bit pulses.
  - dropped pulses high for that one cycle.
  - The suppressed bits' btn_level still rises; they never pulse later for that press.
- Combinational outputs:
  - all_released = ~|btn_level.
  - btn_pulse and dropped are pure flop outputs. all_released is the only combinational output.
- Held button: btn_level stays 1 and produces no further pulses. There is no auto-repeat.
- Re-press: a new pulse requires btn_level[i] to return to 0, then rise again. That is at least 2*DEBOUNCE_CYCLES cycles between pulses on the same bit.
- Reset mid-count: counts are discarded. A button physically held through reset deasserting produces a pulse DEBOUNCE_CYCLES+2 cycles later.
- Counter width: cnt never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.

Test Plan (DEBOUNCE_CYCLES=4):
- Clean press, right:
  - Stimulus: reset, then btn_raw=5'b00001 held.
  - Required: btn_level[0]=1 at edge 6; btn_pulse=5'b00001 for exactly one cycle; all_released falls at edge 6.
  - Release: btn_raw=0 gives btn_level=0 six edges later with no pulse; all_released=1.
- Bounce, left:
  - Stimulus: btn_raw[1] toggles 1,0,1,0 on alternate cycles, then holds 1.
  - Required: no level change during the bounce; exactly one pulse, 6 edges after the final stable 1.
- Simultaneous press:
  - Stimulus: btn_raw=5'b00110 (left and up) asserted on the same cycle.
  - Required: btn_pulse=5'b00010; dropped=1 for one cycle; btn_level=5'b00110.
- Held then re-press, down:
  - Stimulus: hold down for 40 cycles.
  - Required: one pulse only.
  - Then release for 8 cycles and press again: a second pulse.
- Async reset mid-count:
  - Stimulus: btn_raw=5'b10000, then rst pulsed (not clock-aligned) at cycle 4.
  - Required: all outputs clear immediately; all_released=1.
  - After rst falls with center still held: pulse 6 edges later.
- Short glitch, up:
  - Stimulus: btn_raw[2] high for 3 cycles, then low.
  - Required: btn_level stays 0; no pulse; dropped stays 0.

Source files
------------

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
//
// Input stage for the tic-tac-toe board controller. It turns the five raw,
// bouncing, asynchronous push buttons into clean signals for the controller's
// press/release state machine.
//
// Ports:
//   clk           system clock, all state updates on posedge
//   rst           asynchronous, active-high reset
//   btn_raw[4:0]  raw buttons {center, down, up, left, right}, bit 0 = right
//   btn_level     debounced button levels, same bit order
//   btn_pulse     registered one-cycle press pulse, at most one bit set
//   all_released  high whenever no debounced level is set
//   dropped       registered one-cycle flag: a simultaneous press lost the
//                 priority arbitration and was not pulsed
// -----------------------------------------------------------------------------
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] btn_raw,
  output logic [4:0] btn_level,
  output logic [4:0] btn_pulse,
  output logic       all_released,
  output logic       dropped
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [4:0]       sync_a;
  logic [4:0]       s;
  logic [CNT_W-1:0] cnt [5];
  logic [4:0]       at_terminal;
  logic [4:0]       rise;
  logic [4:0]       first_rise;

  // Two-flop synchronizer per button; s is the metastability-safe copy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_a <= '0;
      s      <= '0;
    end else begin
      sync_a <= btn_raw;
      s      <= sync_a;
    end
  end

  // A bit is about to change its debounced level when the synchronized value
  // still disagrees with it and the counter has reached its terminal value.
  // rise is the subset of those changes that go 0 -> 1 at this edge.
  // The lowest set bit wins because the controller decodes right first, and
  // right sits at bit 0; x & -x isolates that bit.
  always_comb begin
    at_terminal = '0;
    for (int i = 0; i < 5; i++) begin
      at_terminal[i] = (s[i] != btn_level[i]) && (cnt[i] == CNT_LAST);
    end
    rise       = at_terminal & s & ~btn_level;
    first_rise = rise & (~rise + 5'd1);
  end

  // Per-bit debounce counters. Agreement with the current level, or any
  // bounce back to it, clears the count, so only an unbroken run of
  // DEBOUNCE_CYCLES disagreeing samples moves the level. The counter is
  // cleared at the terminal count, so it never exceeds CNT_LAST.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_level <= '0;
      for (int i = 0; i < 5; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 5; i++) begin
        if (s[i] == btn_level[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          btn_level[i] <= s[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Press pulse lines up with the cycle in which the level first reads 1.
  // Presses that lose arbitration are reported once through dropped and are
  // never pulsed later, since their level has already risen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      btn_pulse <= '0;
      dropped   <= 1'b0;
    end else begin
      btn_pulse <= first_rise;
      dropped   <= |(rise & ~first_rise);
    end
  end

  assign all_released = ~|btn_level;

endmodule
